// File: rtl/sram_pkg.sv
// Shared types and constants for the dual-port SRAM.
// Shared by sram_2rw_param and its testbench.
package sram_pkg;

  // Two-state controller: zero the array after reset, then serve both ports.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sram_state_e;

  // Port whose write is kept when both ports write the same word.
  localparam int unsigned COLLISION_WINNER = 0;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data pipeline for one SRAM port.
// There is one stage, or two when OUT_REG is 1.
// dout holds its last result between reads, and dvalid marks a fresh result.
module sram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rdEn_i,
  input  logic [DATA_WIDTH-1:0] rdData_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dvalid_o
);

  logic [DATA_WIDTH-1:0] s1Data_q;
  logic                  s1Valid_q;

  // First stage captures array data on an accepted read and otherwise holds it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Data_q  <= '0;
      s1Valid_q <= 1'b0;
    end else begin
      s1Valid_q <= rdEn_i;
      if (rdEn_i) s1Data_q <= rdData_i;
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic [DATA_WIDTH-1:0] s2Data_q;
      logic                  s2Valid_q;

      // Output stage follows the first stage every cycle, so back-to-back reads see no bubbles.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2Data_q  <= '0;
          s2Valid_q <= 1'b0;
        end else begin
          s2Valid_q <= s1Valid_q;
          if (s1Valid_q) s2Data_q <= s1Data_q;
        end
      end

      assign dout_o   = s2Data_q;
      assign dvalid_o = s2Valid_q;
    end else begin : gNoOutReg
      assign dout_o   = s1Data_q;
      assign dvalid_o = s1Valid_q;
    end
  endgenerate

endmodule

// File: rtl/sram_2rw_param.sv
// Dual-port read/write SRAM with a self-clearing sweep after reset.
// Reads are read-first: a read returns the word as it was before any same-cycle write.
// When both ports write one address in the same cycle, port 0 wins.
// Defining SRAM_WMASK_EN adds per-byte write masks (wmask0/wmask1).
module sram_2rw_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csb0,
  input  logic                    csb1,
  input  logic                    web0,
  input  logic                    web1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   din0,
  input  logic [DATA_WIDTH-1:0]   din1,
`ifdef SRAM_WMASK_EN
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [DATA_WIDTH/8-1:0] wmask1,
`endif
  output logic [DATA_WIDTH-1:0]   dout0,
  output logic [DATA_WIDTH-1:0]   dout1,
  output logic                    dvalid0,
  output logic                    dvalid1,
  output logic                    init_busy,
  output logic                    collision
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] initAddr_q, initAddr_d;
  logic                  collision_q, collision_d;

  logic                  wrEn0, wrEn1, rdEn0, rdEn1;
  logic                  sameAddrWr, wrKeep0, wrKeep1;
  logic [NUM_BYTES-1:0]  mask0, mask1;
  logic [DATA_WIDTH-1:0] rdData0, rdData1;

`ifdef SRAM_WMASK_EN
  assign mask0 = wmask0;
  assign mask1 = wmask1;
`else
  assign mask0 = '1;
  assign mask1 = '1;
`endif

  assign init_busy = (state_q == INIT);
  assign collision = collision_q;

  assign wrEn0 = !csb0 && !web0 && !init_busy;
  assign wrEn1 = !csb1 && !web1 && !init_busy;
  assign rdEn0 = !csb0 &&  web0 && !init_busy;
  assign rdEn1 = !csb1 &&  web1 && !init_busy;

  // A same-address double write drops the losing port's whole word, whatever its mask.
  assign sameAddrWr = wrEn0 && wrEn1 && (addr0 == addr1);
  assign wrKeep0    = wrEn0 && !(sameAddrWr && (COLLISION_WINNER != 0));
  assign wrKeep1    = wrEn1 && !(sameAddrWr && (COLLISION_WINNER == 0));

  // Array reads are combinational, so they see the contents from before this edge's writes.
  assign rdData0 = mem[addr0];
  assign rdData1 = mem[addr1];

  // Next state: sweep addresses upward, stop at the last one, and stay READY until reset.
  always_comb begin
    state_d     = state_q;
    initAddr_d  = initAddr_q;
    collision_d = sameAddrWr;
    case (state_q)
      INIT: begin
        if (initAddr_q == LAST_ADDR) state_d = READY;
        else                         initAddr_d = initAddr_q + 1'b1;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Controller registers. Reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      initAddr_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      initAddr_q  <= initAddr_d;
      collision_q <= collision_d;
    end
  end

  // Array writes: a zero word during the sweep, otherwise masked port writes, with port 0 written last.
  // The array itself is never reset; only the sweep clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_busy) begin
        mem[initAddr_q] <= '0;
      end else begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wrKeep1 && mask1[b]) mem[addr1][8*b +: 8] <= din1[8*b +: 8];
          if (wrKeep0 && mask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
        end
      end
    end
  end

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) uRdPipe0 (
    .clk_i    (clk),
    .rst_i    (rst),
    .rdEn_i   (rdEn0),
    .rdData_i (rdData0),
    .dout_o   (dout0),
    .dvalid_o (dvalid0)
  );

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) uRdPipe1 (
    .clk_i    (clk),
    .rst_i    (rst),
    .rdEn_i   (rdEn1),
    .rdData_i (rdData1),
    .dout_o   (dout1),
    .dvalid_o (dvalid1)
  );

endmodule

// File: tb/tb_sram_2rw_param.sv
// Testbench for sram_2rw_param (32-bit words, 128 addresses).
// A reference memory model predicts every output, cycle by cycle.
module tb_sram_2rw_param;

  localparam int DW      = 32;
  localparam int AW      = 7;
  localparam int DEPTH   = 1 << AW;
  localparam int OUT_REG = 0;
  localparam int LAT     = 1 + OUT_REG;

  logic          clk = 1'b0;
  logic          rst, csb0, csb1, web0, web1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, din1, dout0, dout1;
  logic [3:0]    wmask0, wmask1;
  logic          dvalid0, dvalid1, init_busy, collision;

  always #5 clk = ~clk;

  sram_2rw_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(OUT_REG)) dut (
    .clk       (clk),
    .rst       (rst),
    .csb0      (csb0),
    .csb1      (csb1),
    .web0      (web0),
    .web1      (web1),
    .addr0     (addr0),
    .addr1     (addr1),
    .din0      (din0),
    .din1      (din1),
`ifdef SRAM_WMASK_EN
    .wmask0    (wmask0),
    .wmask1    (wmask1),
`endif
    .dout0     (dout0),
    .dout1     (dout1),
    .dvalid0   (dvalid0),
    .dvalid1   (dvalid1),
    .init_busy (init_busy),
    .collision (collision)
  );

  int          vectors     = 0;
  int          miscompares = 0;

  logic [31:0] mdl [DEPTH];
  int          initRemain  = 0;
  logic        hv [2][2];
  logic [31:0] hd [2][2];
  logic [31:0] expDout [2];
  logic        expValid [2];
  logic        expColl;

  // Count one comparison and report it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdlWrite(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (m[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
  endtask

  // Drive one cycle, update the model at the clock edge, then compare every output.
  task automatic applyStimulus(input logic r,
                               input logic c0, input logic w0, input logic [AW-1:0] a0,
                               input logic [31:0] d0, input logic [3:0] m0,
                               input logic c1, input logic w1, input logic [AW-1:0] a1,
                               input logic [31:0] d1, input logic [3:0] m1);
    logic        rv [2];
    logic [31:0] rd [2];
    logic        we0, we1;
    logic [3:0]  em0, em1;
    rst = r; csb0 = c0; web0 = w0; addr0 = a0; din0 = d0; wmask0 = m0;
    csb1 = c1; web1 = w1; addr1 = a1; din1 = d1; wmask1 = m1;
    @(posedge clk);
    rv[0] = 1'b0; rv[1] = 1'b0; rd[0] = '0; rd[1] = '0;
    if (r) begin
      initRemain = DEPTH;
      expColl    = 1'b0;
      for (int p = 0; p < 2; p++) begin
        hv[p][0] = 1'b0; hv[p][1] = 1'b0;
        expDout[p] = '0; expValid[p] = 1'b0;
      end
    end else begin
      if (initRemain > 0) begin
        mdl[DEPTH - initRemain] = '0;
        initRemain--;
        expColl = 1'b0;
      end else begin
`ifdef SRAM_WMASK_EN
        em0 = m0; em1 = m1;
`else
        em0 = 4'hF; em1 = 4'hF;
`endif
        rv[0] = !c0 && w0;  rd[0] = mdl[a0];
        rv[1] = !c1 && w1;  rd[1] = mdl[a1];
        we0 = !c0 && !w0;
        we1 = !c1 && !w1;
        expColl = we0 && we1 && (a0 == a1);
        if (we1 && !expColl) mdlWrite(a1, d1, em1);
        if (we0)             mdlWrite(a0, d0, em0);
      end
      for (int p = 0; p < 2; p++) begin
        hv[p][1] = hv[p][0]; hd[p][1] = hd[p][0];
        hv[p][0] = rv[p];    hd[p][0] = rd[p];
        expValid[p] = hv[p][LAT-1];
        if (expValid[p]) expDout[p] = hd[p][LAT-1];
      end
    end
    #1;
    checkOutput("dout0",     dout0,              expDout[0]);
    checkOutput("dout1",     dout1,              expDout[1]);
    checkOutput("dvalid0",   32'(dvalid0),       32'(expValid[0]));
    checkOutput("dvalid1",   32'(dvalid1),       32'(expValid[1]));
    checkOutput("init_busy", 32'(init_busy),     32'(initRemain > 0));
    checkOutput("collision", 32'(collision),     32'(expColl));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, '0, '0);
  endtask

  task automatic readBoth(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    applyStimulus(1'b0, 1'b0, 1'b1, a0, '0, '0, 1'b0, 1'b1, a1, '0, '0);
    if (LAT > 1) idle(LAT - 1);
  endtask

  // Wait out a clear while port 0 keeps trying to write; returns the number of busy samples.
  task automatic clearWithWrites(output int busyCnt);
    busyCnt = init_busy ? 1 : 0;
    for (int n = 0; n < 200; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 7'($urandom_range(0, DEPTH-1)), $urandom, 4'hF,
                    1'b1, 1'b1, '0, '0, '0);
      if (!init_busy) break;
      busyCnt++;
    end
  endtask

  initial begin
    int busyCnt;
    expColl = 1'b0;

    // Reset, part of a clear with write attempts, then a reset at clear cycle 60.
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, '0, '0);
    for (int i = 0; i < 60; i++)
      applyStimulus(1'b0, 1'b0, 1'b0, 7'($urandom_range(0, DEPTH-1)), $urandom, 4'hF,
                    1'b1, 1'b1, '0, '0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b1, 1'b1, '0, '0, '0);
    clearWithWrites(busyCnt);
    checkOutput("initLen", 32'(busyCnt), 32'd128);
    checkOutput("clearDone", 32'(init_busy), 32'd0);

    // The sweep leaves zeros everywhere, including the first and last address.
    readBoth(7'd0, 7'd127);
    checkOutput("zero0", dout0, 32'h0);
    checkOutput("zero127", dout1, 32'h0);
    readBoth(7'd100, 7'd60);

    // Port 0 writes, then port 1 reads the same word on the next cycle.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd5, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, '0, '0, '0);
    readBoth(7'd0, 7'd5);
    checkOutput("wrThenRd", dout1, 32'hDEADBEEF);
    checkOutput("wrThenRdV", 32'(dvalid1), 32'd1);

    // Both ports write one address: the collision pulse, port 0's data, and identical dual reads.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd9, 32'h11111111, 4'hF, 1'b0, 1'b0, 7'd9, 32'h22222222, 4'hF);
    checkOutput("collPulse", 32'(collision), 32'd1);
    idle(1);
    checkOutput("collDrop", 32'(collision), 32'd0);
    readBoth(7'd9, 7'd9);
    checkOutput("collWin0", dout0, 32'h11111111);
    checkOutput("collWin1", dout1, 32'h11111111);

    // Read-first: port 1 reads a word in the same cycle that port 0 writes it.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd3, 32'hAAAA5555, 4'hF, 1'b0, 1'b1, 7'd3, '0, '0);
    if (LAT > 1) idle(LAT - 1);
    checkOutput("rdFirstOld", dout1, 32'h0);
    readBoth(7'd0, 7'd3);
    checkOutput("rdFirstNew", dout1, 32'hAAAA5555);
    idle(2);
    checkOutput("holdData", dout1, 32'hAAAA5555);
    checkOutput("holdValid", 32'(dvalid1), 32'd0);

`ifdef SRAM_WMASK_EN
    // Byte masks: only the enabled bytes change.
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd7, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd7, 32'h12345678, 4'b0101, 1'b1, 1'b1, '0, '0, '0);
    readBoth(7'd7, 7'd7);
    checkOutput("wmask", dout0, 32'hFF34FF78);
`endif

    // Random traffic over a small address window so that collisions and read-first cases occur.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'b0,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)));

    // Reset while reads are in flight: they are discarded and the clear restarts.
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, '0, '0, 1'b0, 1'b1, 7'd9, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 7'd5, '0, '0, 1'b0, 1'b1, 7'd9, '0, '0);
    checkOutput("rstDout", dout0, 32'h0);
    clearWithWrites(busyCnt);
    checkOutput("initLen2", 32'(busyCnt), 32'd128);
    readBoth(7'd5, 7'd9);
    checkOutput("reclear", dout0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_2rw_param.md
SRAM_2RW_PARAM -- requirements
Module: sram_2rw_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 7, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
REQ-003 Parameter OUT_REG, default 0, adds an output register stage when 1: read latency is 1 + OUT_REG.
REQ-004 Port clk  input  1  the single clock; all state updates on posedge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Ports csb0/csb1  input  1  active-low chip select, per port.
REQ-007 Ports web0/web1  input  1  active-low write enable, per port.
REQ-008 Ports addr0/addr1  input  ADDR_WIDTH  word address, per port.
REQ-009 Ports din0/din1  input  DATA_WIDTH  write data, per port.
REQ-010 Ports wmask0/wmask1  input  DATA_WIDTH/8  byte write mask, bit i covers din[8i+7:8i]; present only under SRAM_WMASK_EN.
REQ-011 Ports dout0/dout1  output  DATA_WIDTH  read data, per port.
REQ-012 Ports dvalid0/dvalid1  output  1  dout holds a fresh read result this cycle.
REQ-013 Port init_busy  output  1  memory clear in progress; accesses ignored.
REQ-014 Port collision  output  1  one-cycle pulse: both ports wrote the same address.

Function
REQ-015 Write: !csbN && !webN && !init_busy at posedge SHALL update mem[addrN] at that edge.
REQ-016 Read: !csbN && webN && !init_busy SHALL drive dout/dvalid exactly 1 + OUT_REG cycles later.
REQ-017 Without a new read, dout SHALL hold its last value (never X) and dvalid SHALL be 0.
REQ-018 Read of an address written by the other port in the same cycle SHALL return the old data (read-first).
REQ-019 Both ports write the same address in the same cycle: port 0 data SHALL win; collision SHALL pulse 1 the following cycle.
REQ-020 Same-address reads on both ports SHALL both return identical data.
REQ-021 FSM states INIT, READY; INIT -> READY after the address counter writes RAM_DEPTH-1; READY has no exit except via reset.
REQ-022 In INIT, counter SHALL write all-zero to one address per cycle from 0 upward; init_busy = 1; port requests SHALL be dropped (no write, no dvalid).
REQ-023 Clear SHALL take exactly RAM_DEPTH cycles; init_busy falls on the edge that writes address RAM_DEPTH-1.
REQ-024 Counter SHALL be ADDR_WIDTH bits and SHALL NOT wrap past RAM_DEPTH-1.
REQ-025 With OUT_REG = 1, dvalid/dout SHALL propagate through both stages without bubbles at one read per cycle per port.

Reset
REQ-026 rst SHALL force: FSM INIT, counter 0, init_busy 1, dout0/dout1 0, dvalid0/dvalid1 0, collision 0, pipeline stages cleared.
REQ-027 Reset mid-clear or mid-read SHALL restart the clear at address 0 and discard in-flight reads.
REQ-028 Memory array contents SHALL NOT be reset directly; only by the INIT sweep.

Configuration
REQ-029 Macro SRAM_WMASK_EN defined: wmask0/wmask1 exist; writes update only bytes with mask bit 1; collision merging SHALL remain whole-word port-0-wins.
REQ-030 SRAM_WMASK_EN undefined: wmask ports absent; every write updates the full word.

Structure
REQ-031 Package sram_pkg SHALL hold the FSM state typedef (INIT, READY) and the localparam for the collision winner port (0).
REQ-032 Sub-module sram_rd_pipe (dout/dvalid stages, parameter OUT_REG) SHALL be instantiated once per port.

Verification (DATA_WIDTH 32, ADDR_WIDTH 7)
REQ-033 rst high 1 cycle, then idle -> init_busy 1 for exactly 128 cycles; any address then reads 0x00000000.
REQ-034 OUT_REG 0: port0 writes 0xDEADBEEF @5, next cycle port1 reads @5 -> dout1 0xDEADBEEF, dvalid1 1 one cycle later.
REQ-035 Same cycle: port0 writes 0x11111111 @9, port1 writes 0x22222222 @9 -> collision 1 for one cycle; later read @9 = 0x11111111.
REQ-036 Port0 writes 0xAAAA5555 @3 while port1 reads @3 (old 0) -> dout1 = 0x00000000; next read @3 = 0xAAAA5555.
REQ-037 SRAM_WMASK_EN, @7 = 0xFFFFFFFF, write 0x12345678 with wmask 4'b0101 -> read @7 = 0xFF34FF78.
REQ-038 rst asserted at clear cycle 60 -> clear restarts at 0, init_busy 1 for 128 further cycles, writes during it are dropped.
